// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: ALUop encodings, internal op codes
// and the sequencing FSM state type.
package alu_pkg;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   function automatic logic op_is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/result bus of the ALU execution unit. Names are from the unit's point of view.
// Handshake: a request transfers on a rising edge where i_valid & o_ready; a result
// transfers on a rising edge where o_valid & i_ready. A producer holds its valid and
// payload steady until the transfer happens.
interface alu_exec_unit_if #(
   parameter int XLEN = 32
);
   logic            i_valid;
   logic            o_ready;
   logic [1:0]      i_ALUop;
   logic [6:0]      i_func7;
   logic [2:0]      i_func3;
   logic [XLEN-1:0] i_a;
   logic [XLEN-1:0] i_b;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_result;
   logic            o_zero;
   logic            o_illegal;

   modport slave (
      input  i_valid, i_ALUop, i_func7, i_func3, i_a, i_b, i_ready,
      output o_ready, o_valid, o_result, o_zero, o_illegal
   );

   modport master (
      output i_valid, i_ALUop, i_func7, i_func3, i_a, i_b, i_ready,
      input  o_ready, o_valid, o_result, o_zero, o_illegal
   );
endinterface

// File: rtl/alu_decode.sv
// Combinational decode of {ALUop, func7, func3} into an internal op code plus an
// illegal flag for keys that name no operation.
module alu_decode
   import alu_pkg::*;
(
   input  logic [1:0] i_ALUop,
   input  logic [6:0] i_func7,
   input  logic [2:0] i_func3,
   output logic [3:0] o_op,
   output logic       o_illegal
);

   always_comb begin
      o_op      = OP_ADD;
      o_illegal = 1'b0;
      case (i_ALUop)
         ALUOP_ADD: o_op = OP_ADD;
         ALUOP_SUB: o_op = OP_SUB;
         ALUOP_R: begin
            case ({i_func7, i_func3})
               {F7_BASE, 3'b000}: o_op = OP_ADD;
               {F7_ALT,  3'b000}: o_op = OP_SUB;
               {F7_BASE, 3'b001}: o_op = OP_SLL;
               {F7_BASE, 3'b010}: o_op = OP_SLT;
               {F7_BASE, 3'b011}: o_op = OP_SLTU;
               {F7_BASE, 3'b100}: o_op = OP_XOR;
               {F7_BASE, 3'b101}: o_op = OP_SRL;
               {F7_ALT,  3'b101}: o_op = OP_SRA;
               {F7_BASE, 3'b110}: o_op = OP_OR;
               {F7_BASE, 3'b111}: o_op = OP_AND;
               default:           o_illegal = 1'b1;
            endcase
         end
         default: begin
            // Immediate forms: func7 only qualifies the shifts, and 000 is always ADD.
            case (i_func3)
               3'b000: o_op = OP_ADD;
               3'b010: o_op = OP_SLT;
               3'b011: o_op = OP_SLTU;
               3'b100: o_op = OP_XOR;
               3'b110: o_op = OP_OR;
               3'b111: o_op = OP_AND;
               3'b001: begin
                  if (i_func7 == F7_BASE) o_op = OP_SLL;
                  else                    o_illegal = 1'b1;
               end
               default: begin
                  if (i_func7 == F7_BASE)     o_op = OP_SRL;
                  else if (i_func7 == F7_ALT) o_op = OP_SRA;
                  else                        o_illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops and multi-cycle shifts that
// advance SHIFT_STEP bit positions per cycle, behind a valid/ready request/result bus.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   alu_exec_unit_if.slave    bus,
   output state_t            o_state
);

   localparam int              SHW    = $clog2(XLEN);
   localparam logic [SHW:0]    STEP_W = (SHW + 1)'(SHIFT_STEP);

   state_t            r_state;
   logic [3:0]        r_op;
   logic [XLEN-1:0]   r_result;
   logic              r_illegal;
   logic [SHW-1:0]    r_cnt;

   logic [3:0]        w_op;
   logic              w_illegal;
   logic              w_accept;
   logic [SHW-1:0]    w_shamt;
   logic [XLEN-1:0]   w_alu_res;
   logic [SHW:0]      w_cnt_ext;
   logic [SHW:0]      w_step;
   logic              w_last;
   logic [XLEN-1:0]   w_shift_val;

   alu_decode u_decode (
      .i_ALUop   (bus.i_ALUop),
      .i_func7   (bus.i_func7),
      .i_func3   (bus.i_func3),
      .o_op      (w_op),
      .o_illegal (w_illegal)
   );

   assign bus.o_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.i_ready);
   assign bus.o_valid   = (r_state == ST_DONE);
   assign bus.o_result  = r_result;
   assign bus.o_zero    = (r_result == '0);
   assign bus.o_illegal = r_illegal;
   assign o_state       = r_state;

   assign w_accept  = bus.i_valid && bus.o_ready;
   assign w_shamt   = bus.i_b[SHW-1:0];
   assign w_cnt_ext = {1'b0, r_cnt};
   assign w_step    = (w_cnt_ext < STEP_W) ? w_cnt_ext : STEP_W;
   assign w_last    = (w_cnt_ext <= STEP_W);

   // Shift ops fall to the default: a zero-amount shift returns the operand unchanged.
   always_comb begin
      w_alu_res = bus.i_a;
      case (w_op)
         OP_AND:  w_alu_res = bus.i_a & bus.i_b;
         OP_OR:   w_alu_res = bus.i_a | bus.i_b;
         OP_ADD:  w_alu_res = bus.i_a + bus.i_b;
         OP_XOR:  w_alu_res = bus.i_a ^ bus.i_b;
         OP_SUB:  w_alu_res = bus.i_a - bus.i_b;
         OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
         OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (bus.i_a < bus.i_b)};
         default: w_alu_res = bus.i_a;
      endcase
   end

   // The working value keeps its MSB as the captured sign, so >>> replicates it.
   always_comb begin
      w_shift_val = r_result;
      case (r_op)
         OP_SLL:  w_shift_val = r_result << w_step;
         OP_SRL:  w_shift_val = r_result >> w_step;
         OP_SRA:  w_shift_val = $unsigned($signed(r_result) >>> w_step);
         default: w_shift_val = r_result;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_op      <= OP_ADD;
         r_result  <= '0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            ST_SHIFT: begin
               r_result <= w_shift_val;
               r_cnt    <= r_cnt - w_step[SHW-1:0];
               if (w_last) r_state <= ST_DONE;
            end
            default: begin
               if (w_accept) begin
                  r_op      <= w_op;
                  r_illegal <= w_illegal;
                  if (w_illegal) begin
                     r_result <= '0;
                     r_cnt    <= '0;
                     r_state  <= ST_DONE;
                  end else if (op_is_shift(w_op) && (w_shamt != '0)) begin
                     r_result <= bus.i_a;
                     r_cnt    <= w_shamt;
                     r_state  <= ST_SHIFT;
                  end else begin
                     r_result <= w_alu_res;
                     r_cnt    <= '0;
                     r_state  <= ST_DONE;
                  end
               end else if ((r_state == ST_DONE) && bus.i_ready) begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: two instances (SHIFT_STEP 1 and 4) share one stimulus bus;
// expected results are queued at acceptance and checked by a monitor on the result side.
module tb_alu_exec_unit;
   import alu_pkg::*;

   localparam int EW = 41;  // {latency[7:0], illegal, result[31:0]}

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        t_valid = 1'b0;
   logic        t_sel = 1'b0;
   logic        rdy = 1'b1;
   logic [1:0]  t_op = 2'b00;
   logic [6:0]  t_f7 = 7'd0;
   logic [2:0]  t_f3 = 3'd0;
   logic [31:0] t_a = 32'd0;
   logic [31:0] t_b = 32'd0;

   int          cyc = 0;
   logic [EW-1:0] exp_q[$];
   int          acc_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          presenting = 1'b0;
   state_t      st0, st1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_exec_unit_if #(.XLEN(32)) if0 ();
   alu_exec_unit_if #(.XLEN(32)) if1 ();

   assign if0.i_valid = t_valid && (t_sel == 1'b0);
   assign if1.i_valid = t_valid && (t_sel == 1'b1);
   assign if0.i_ALUop = t_op;
   assign if1.i_ALUop = t_op;
   assign if0.i_func7 = t_f7;
   assign if1.i_func7 = t_f7;
   assign if0.i_func3 = t_f3;
   assign if1.i_func3 = t_f3;
   assign if0.i_a     = t_a;
   assign if1.i_a     = t_a;
   assign if0.i_b     = t_b;
   assign if1.i_b     = t_b;
   assign if0.i_ready = rdy;
   assign if1.i_ready = rdy;

   alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) u_dut0 (
      .i_clk (clk), .i_rst (rst), .bus (if0.slave), .o_state (st0)
   );

   alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) u_dut1 (
      .i_clk (clk), .i_rst (rst), .bus (if1.slave), .o_state (st1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic mon(input logic v, input logic r, input logic [31:0] res,
                      input logic z, input logic ill);
      logic [EW-1:0] e;
      int lat;
      if (!v) return;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_result actual=%h required=none (cycle %0d)", res, cyc);
         return;
      end
      e = exp_q[0];
      chk("result", res, e[31:0]);
      chk("zero", 32'(z), 32'(e[31:0] == 32'd0));
      chk("illegal", 32'(ill), 32'(e[32]));
      if (!presenting) begin
         lat = cyc - acc_q[0];
         chk("latency", 32'(lat), 32'(e[40:33]));
      end
      if (r) begin
         void'(exp_q.pop_front());
         void'(acc_q.pop_front());
         presenting = 1'b0;
      end else begin
         presenting = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      #2;
      mon(if0.o_valid, if0.i_ready, if0.o_result, if0.o_zero, if0.o_illegal);
      mon(if1.o_valid, if1.i_ready, if1.o_result, if1.o_zero, if1.o_illegal);
   end

   task automatic issue(input logic sel, input logic [1:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ill, input int lat);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      @(negedge clk);
      t_sel = sel; t_op = op; t_f7 = f7; t_f3 = f3; t_a = a; t_b = b;
      t_valid = 1'b1;
      rdy = 1'b1;
      while (!ok && n < 100) begin
         #1;
         if (sel ? if1.o_ready : if0.o_ready) ok = 1'b1;
         else begin
            n++;
            @(negedge clk);
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=not_ready required=ready (cycle %0d)", cyc);
         t_valid = 1'b0;
         return;
      end
      exp_q.push_back({8'(lat), ill, res});
      acc_q.push_back(cyc);
      @(posedge clk);
      #1;
      t_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      #3;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
         exp_q.delete();
         acc_q.delete();
         presenting = 1'b0;
      end
   endtask

   initial begin
      // Request held during reset must not be taken.
      rst = 1'b1;
      t_valid = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      t_valid = 1'b0;
      #1;
      chk("rst_state0", 32'(st0), 32'(ST_IDLE));
      chk("rst_state1", 32'(st1), 32'(ST_IDLE));
      chk("rst_valid", 32'(if0.o_valid), 32'd0);
      chk("rst_ready", 32'(if0.o_ready), 32'd1);
      chk("rst_result", if0.o_result, 32'd0);
      chk("rst_zero", 32'(if0.o_zero), 32'd1);
      chk("rst_illegal", 32'(if0.o_illegal), 32'd0);
      @(negedge clk);
      #1;
      chk("post_rst_valid", 32'(if0.o_valid), 32'd0);

      issue(1'b0, ALUOP_R, 7'h00, 3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1);
      issue(1'b0, ALUOP_R, 7'h20, 3'b101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 5);
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("ready_in_shift", 32'(if0.o_ready), 32'd0);
      end
      issue(1'b0, ALUOP_R, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
      issue(1'b0, ALUOP_R, 7'h00, 3'b011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
      issue(1'b0, ALUOP_SUB, 7'h00, 3'b000, 32'd5, 32'd5, 32'd0, 1'b0, 1);
      issue(1'b0, ALUOP_ADD, 7'h00, 3'b000, 32'd7, 32'hFFFFFFFF, 32'd6, 1'b0, 1);
      issue(1'b0, ALUOP_I, 7'h20, 3'b000, 32'd10, 32'd3, 32'd13, 1'b0, 1);
      issue(1'b0, ALUOP_I, 7'h55, 3'b110, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1);
      issue(1'b0, ALUOP_I, 7'h20, 3'b001, 32'd3, 32'd2, 32'd0, 1'b1, 1);
      issue(1'b0, ALUOP_R, 7'h00, 3'b001, 32'd3, 32'h00000022, 32'd12, 1'b0, 3);
      issue(1'b0, ALUOP_R, 7'h00, 3'b101, 32'hF0000000, 32'h00000124, 32'h0F000000, 1'b0, 5);
      issue(1'b0, ALUOP_R, 7'h00, 3'b111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1);

      // Illegal result held for three cycles, then an ADD in the release cycle.
      issue(1'b0, ALUOP_R, 7'h20, 3'b111, 32'h00001234, 32'h00005678, 32'd0, 1'b1, 1);
      rdy = 1'b0;
      repeat (3) @(negedge clk);
      issue(1'b0, ALUOP_ADD, 7'h00, 3'b000, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1);
      drain();

      // Reset in the middle of a long shift: the result is abandoned.
      issue(1'b0, ALUOP_R, 7'h00, 3'b001, 32'd1, 32'd20, 32'h00100000, 1'b0, 21);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      acc_q.delete();
      presenting = 1'b0;
      chk("abort_state", 32'(st0), 32'(ST_IDLE));
      chk("abort_valid", 32'(if0.o_valid), 32'd0);
      chk("abort_ready", 32'(if0.o_ready), 32'd1);
      chk("abort_result", if0.o_result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);

      issue(1'b1, ALUOP_R, 7'h00, 3'b001, 32'd1, 32'd31, 32'h80000000, 1'b0, 9);
      issue(1'b1, ALUOP_R, 7'h00, 3'b101, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1'b0, 1);
      issue(1'b1, ALUOP_R, 7'h20, 3'b101, 32'h80000010, 32'd6, 32'hFE000000, 1'b0, 3);
      drain();
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
